// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared constants for the digital-clock time-keeping core.
//   - BCD range limits for seconds, minutes and hours (24- and 12-hour)
//   - FSM state encoding (RUN / SET)
//   - bcd2_next(): next value of a packed 2-digit BCD counter
// -----------------------------------------------------------------------------
package clock_pkg;

  localparam logic [7:0] SEC_MAX    = 8'h59;
  localparam logic [7:0] MIN_MAX    = 8'h59;
  localparam logic [7:0] HOUR_MAX24 = 8'h23;
  localparam logic [7:0] HOUR_MAX12 = 8'h12;
  localparam logic [7:0] HOUR_MIN12 = 8'h01;

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_SET = 1'b1;

  // Step a packed BCD pair (high nibble = tens) by one, wrapping max -> min.
  // Only legal digits are ever produced as long as the input is legal.
  function automatic logic [7:0] bcd2_next(input logic [7:0] value,
                                           input logic [7:0] max_val,
                                           input logic [7:0] min_val);
    logic [7:0] nxt;
    if (value == max_val)
      nxt = min_val;
    else if (value[3:0] == 4'd9)
      nxt = {value[7:4] + 4'd1, 4'd0};
    else
      nxt = {value[7:4], value[3:0] + 4'd1};
    return nxt;
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// -----------------------------------------------------------------------------
// bcd2_counter
// Two-digit packed BCD counter with configurable range.
// Parameters:
//   MAX     - last value before wrapping (BCD)
//   MIN     - value loaded on wrap (BCD)
//   RST_VAL - value loaded on reset or clear (BCD)
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset (loads RST_VAL)
//   clear  in   synchronous load of RST_VAL (lower priority than reset)
//   inc    in   advance by one on this edge
//   value  out  current count, packed BCD
//   wrap   out  combinational: inc is high and value is at MAX, so the next
//               stage can advance on the same edge (no ripple delay)
// -----------------------------------------------------------------------------
module bcd2_counter #(
  parameter logic [7:0] MAX     = 8'h59,
  parameter logic [7:0] MIN     = 8'h00,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] value,
  output logic       wrap
);
  import clock_pkg::*;

  assign wrap = inc && (value == MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear)
      value <= RST_VAL;
    else if (inc)
      value <= bcd2_next(value, MAX, MIN);
  end

endmodule

// File: rtl/time_counter.sv
// -----------------------------------------------------------------------------
// time_counter
// Time-keeping core of the digital clock: divides clk to a 1 Hz tick and keeps
// seconds/minutes/hours as packed 2-digit BCD. A SET mode lets push-buttons
// adjust minutes and hours.
// Build option: define TIME_COUNTER_HOUR12_EN for 12-hour mode with a PM flag;
// otherwise 24-hour mode with pm tied low.
// Parameters:
//   TICK_DIV - clk cycles per second tick (>= 2)
//   DB_BITS  - extra synchroniser stages beyond the first (1 = two-flop chain)
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   run       in   1 = time advances, 0 = time frozen
//   set_mode  in   1 = SET state, 0 = RUN state (asynchronous level)
//   inc_min   in   button level, rising edge bumps minutes in SET
//   inc_hour  in   button level, rising edge bumps hours in SET
//   bcd_s     out  seconds BCD
//   bcd_m     out  minutes BCD
//   bcd_h     out  hours BCD
//   sec_tick  out  one-cycle pulse after each seconds advance
//   pm        out  PM indicator (12-hour build only)
// -----------------------------------------------------------------------------
module time_counter #(
  parameter int TICK_DIV = 100000000,
  parameter int DB_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [7:0] bcd_s,
  output logic [7:0] bcd_m,
  output logic [7:0] bcd_h,
  output logic       sec_tick,
  output logic       pm
);
  import clock_pkg::*;

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

`ifdef TIME_COUNTER_HOUR12_EN
  localparam logic [7:0] H_MAX   = HOUR_MAX12;
  localparam logic [7:0] H_MIN   = HOUR_MIN12;
  localparam logic [7:0] H_RST   = HOUR_MAX12;
  // 11 -> 12 is the only hour step that flips AM/PM.
  localparam logic [7:0] H_FLIP  = 8'h11;
`else
  localparam logic [7:0] H_MAX   = HOUR_MAX24;
  localparam logic [7:0] H_MIN   = 8'h00;
  localparam logic [7:0] H_RST   = 8'h00;
`endif

  // Input synchroniser: bit 2 = set_mode, bit 1 = inc_hour, bit 0 = inc_min.
  logic [2:0]    sync_q [DB_BITS+1];
  logic          set_sync, hour_sync, min_sync;
  logic          min_prev, hour_prev;
  logic [0:0]    state;
  logic [PW-1:0] prescaler;
  logic          in_set, tick, min_edge, hour_edge;
  logic          s_inc, m_inc, h_inc;
  logic          s_wrap, m_wrap, h_wrap_unused;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= DB_BITS; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {set_mode, inc_hour, inc_min};
      for (int i = 1; i <= DB_BITS; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {set_sync, hour_sync, min_sync} = sync_q[DB_BITS];

  assign in_set    = (state == ST_SET);
  // Edges are only honoured in SET; presses seen in RUN are dropped.
  assign min_edge  = min_sync  & ~min_prev;
  assign hour_edge = hour_sync & ~hour_prev;

  // A pending SET entry (set_sync already high, state still RUN) suppresses
  // the tick so a terminal count on that edge cannot advance seconds.
  assign tick  = run && !in_set && !set_sync && (prescaler == PRE_LAST);

  assign s_inc = tick;
  assign m_inc = in_set ? min_edge  : s_wrap;
  assign h_inc = in_set ? hour_edge : m_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      prescaler <= '0;
      sec_tick  <= 1'b0;
      min_prev  <= 1'b0;
      hour_prev <= 1'b0;
    end else begin
      state     <= set_sync ? ST_SET : ST_RUN;
      min_prev  <= min_sync;
      hour_prev <= hour_sync;
      sec_tick  <= tick;
      if (in_set || tick)
        prescaler <= '0;
      else if (run && !set_sync)
        prescaler <= prescaler + PW'(1);
    end
  end

  bcd2_counter #(.MAX(SEC_MAX), .MIN(8'h00), .RST_VAL(8'h00)) u_sec (
    .clk   (clk),
    .reset (reset),
    .clear (in_set),
    .inc   (s_inc),
    .value (bcd_s),
    .wrap  (s_wrap)
  );

  bcd2_counter #(.MAX(MIN_MAX), .MIN(8'h00), .RST_VAL(8'h00)) u_min (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (m_inc),
    .value (bcd_m),
    .wrap  (m_wrap)
  );

  bcd2_counter #(.MAX(H_MAX), .MIN(H_MIN), .RST_VAL(H_RST)) u_hour (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (h_inc),
    .value (bcd_h),
    .wrap  (h_wrap_unused)
  );

`ifdef TIME_COUNTER_HOUR12_EN
  always_ff @(posedge clk) begin
    if (reset)
      pm <= 1'b0;
    else if (h_inc && (bcd_h == H_FLIP))
      pm <= ~pm;
  end
`else
  assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_time_counter.sv
// -----------------------------------------------------------------------------
// tb_time_counter
// Self-checking bench for time_counter with TICK_DIV = 4. A table of per-cycle
// vectors covers reset, tick cadence, run hold and SET entry on a terminal
// count; hand-written sequences cover carries, SET adjustment and reset while
// buttons are held. Every sec_tick is matched against a queue of expected
// times filled by the stimulus side from an integer time-of-day model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_time_counter;

  localparam int TICK_DIV = 4;
`ifdef TIME_COUNTER_HOUR12_EN
  localparam logic [7:0] H_RST = 8'h12;
`else
  localparam logic [7:0] H_RST = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1, run = 1'b0, set_mode = 1'b0;
  logic       inc_min = 1'b0, inc_hour = 1'b0;
  logic [7:0] bcd_s, bcd_m, bcd_h;
  logic       sec_tick, pm;

  time_counter #(.TICK_DIV(TICK_DIV), .DB_BITS(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .set_mode (set_mode),
    .inc_min  (inc_min),
    .inc_hour (inc_hour),
    .bcd_s    (bcd_s),
    .bcd_m    (bcd_m),
    .bcd_h    (bcd_h),
    .sec_tick (sec_tick),
    .pm       (pm)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic       pm;
  } tod_t;

  typedef struct {
    logic       rst;
    logic       run;
    logic       set;
    logic [7:0] s;
    logic       tick;
  } vec_t;

  tod_t exp_q[$];
  vec_t vecs[29];
  int   eh, em, es;   // reference time of day, 24-hour integers

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t, u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  function automatic tod_t model_tod();
    tod_t t;
    int   hd;
`ifdef TIME_COUNTER_HOUR12_EN
    hd   = (eh % 12 == 0) ? 12 : eh % 12;
    t.pm = (eh >= 12);
`else
    hd   = eh;
    t.pm = 1'b0;
`endif
    t.h = to_bcd(hd);
    t.m = to_bcd(em);
    t.s = to_bcd(es);
    return t;
  endfunction

  function automatic vec_t mkv(input logic rst, input logic rn, input logic st,
                               input logic [7:0] s, input logic tk);
    vec_t v;
    v.rst = rst; v.run = rn; v.set = st; v.s = s; v.tick = tk;
    return v;
  endfunction

  // Compare all time outputs (hhmmss, then pm in the low byte) with the model.
  task automatic check_tod(input string name);
    tod_t e;
    e = model_tod();
    check(name, {bcd_h, bcd_m, bcd_s, 7'd0, pm}, {e.h, e.m, e.s, 7'd0, e.pm});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; set_mode = 1'b0; inc_min = 1'b0; inc_hour = 1'b0;
    eh = 0; em = 0; es = 0;
    step();
    check_tod("reset_state");
    check("reset_tick", {31'd0, sec_tick}, 32'd0);
    reset = 1'b0;
  endtask

  // Advance the model by n seconds, expecting one sec_tick per second.
  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      es++;
      if (es == 60) begin es = 0; em++; end
      if (em == 60) begin em = 0; eh = (eh + 1) % 24; end
      exp_q.push_back(model_tod());
      run = 1'b1;
      for (int c = 0; c < 3 * TICK_DIV + 4 && exp_q.size() != 0; c++) step();
      if (exp_q.size() != 0) begin
        checks++;
        failures++;
        $display("FAIL tick_timeout: got no sec_tick required one within %0d cycles", 3 * TICK_DIV + 4);
        exp_q.delete();
      end
    end
    run = 1'b0;
  endtask

  task automatic enter_set();
    run = 1'b0;
    set_mode = 1'b1;
    repeat (4) step();
    es = 0;
    check_tod("enter_set");
  endtask

  task automatic exit_set();
    run = 1'b0;
    set_mode = 1'b0;
    repeat (4) step();
  endtask

  // One button press: high for one cycle, then low long enough for the
  // increment (three edges after the rise) to land before returning.
  task automatic pulse(input logic im, input logic ih, input logic apply);
    inc_min = im; inc_hour = ih;
    step();
    inc_min = 1'b0; inc_hour = 1'b0;
    step();
    step();
    if (apply) begin
      if (im) em = (em + 1) % 60;
      if (ih) eh = (eh + 1) % 24;
    end
  endtask

  // Scoreboard monitor: every sec_tick must match the oldest expected time.
  initial begin : monitor
    tod_t e;
    forever begin
      @(negedge clk);
      if (sec_tick === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_sec_tick: got tick at %02h:%02h:%02h required none", bcd_h, bcd_m, bcd_s);
        end else begin
          e = exp_q.pop_front();
          check("tick_time", {bcd_h, bcd_m, bcd_s, 7'd0, pm}, {e.h, e.m, e.s, 7'd0, e.pm});
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no end of test required finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    tod_t e;

    // Per-cycle vectors {reset, run, set_mode, expected bcd_s, expected sec_tick}.
    vecs[0]  = mkv(1, 0, 0, 8'h00, 0);
    vecs[1]  = mkv(1, 0, 0, 8'h00, 0);
    vecs[2]  = mkv(0, 1, 0, 8'h00, 0);
    vecs[3]  = mkv(0, 1, 0, 8'h00, 0);
    vecs[4]  = mkv(0, 1, 0, 8'h00, 0);
    vecs[5]  = mkv(0, 1, 0, 8'h01, 1);  // 4th edge after reset
    vecs[6]  = mkv(0, 1, 0, 8'h01, 0);
    vecs[7]  = mkv(0, 1, 1, 8'h01, 0);  // set_mode rises
    vecs[8]  = mkv(0, 1, 1, 8'h01, 0);
    vecs[9]  = mkv(0, 1, 1, 8'h01, 0);  // terminal count meets SET entry
    vecs[10] = mkv(0, 1, 1, 8'h00, 0);  // SET clears seconds
    vecs[11] = mkv(0, 1, 1, 8'h00, 0);
    vecs[12] = mkv(1, 1, 0, 8'h00, 0);  // reset while in SET
    vecs[13] = mkv(0, 1, 0, 8'h00, 0);
    vecs[14] = mkv(0, 1, 0, 8'h00, 0);
    vecs[15] = mkv(0, 1, 0, 8'h00, 0);
    vecs[16] = mkv(0, 1, 0, 8'h01, 1);
    vecs[17] = mkv(0, 1, 0, 8'h01, 0);
    vecs[18] = mkv(0, 1, 0, 8'h01, 0);
    vecs[19] = mkv(0, 1, 0, 8'h01, 0);
    vecs[20] = mkv(0, 1, 0, 8'h02, 1);
    vecs[21] = mkv(0, 0, 0, 8'h02, 0);  // run low: frozen
    vecs[22] = mkv(0, 0, 0, 8'h02, 0);
    vecs[23] = mkv(0, 0, 0, 8'h02, 0);
    vecs[24] = mkv(0, 1, 0, 8'h02, 0);
    vecs[25] = mkv(0, 1, 0, 8'h02, 0);
    vecs[26] = mkv(0, 1, 0, 8'h02, 0);
    vecs[27] = mkv(0, 1, 0, 8'h03, 1);
    vecs[28] = mkv(0, 1, 0, 8'h03, 0);

    for (int i = 0; i < 29; i++) begin
      reset = vecs[i].rst; run = vecs[i].run; set_mode = vecs[i].set;
      if (vecs[i].tick) begin
        e.h = H_RST; e.m = 8'h00; e.s = vecs[i].s; e.pm = 1'b0;
        exp_q.push_back(e);
      end
      step();
      check($sformatf("vec%0d_s", i), {24'd0, bcd_s}, {24'd0, vecs[i].s});
      check($sformatf("vec%0d_tick", i), {31'd0, sec_tick}, {31'd0, vecs[i].tick});
      check($sformatf("vec%0d_hm_pm", i), {bcd_h, bcd_m, 7'd0, pm}, {H_RST, 8'h00, 8'h00});
    end
    run = 1'b0;
    step();

    // Seconds 59 -> 00 carries into minutes on the same edge.
    do_reset();
    run_ticks(59);
    check_tod("at_00_00_59");
    run_ticks(1);
    check("s_carry_s", {24'd0, bcd_s}, 32'h00);
    check("s_carry_m", {24'd0, bcd_m}, 32'h01);

    // SET adjustment with wrap, RUN presses discarded, no ticks in SET.
    do_reset();
    enter_set();
    for (int i = 0; i < 10; i++) pulse(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0, 1'b1);
    exit_set();
    run_ticks(33);
    check_tod("at_10_07_33");
    pulse(1'b1, 1'b1, 1'b0);
    check_tod("run_press_ignored");
    enter_set();
    run = 1'b1;
    for (int i = 1; i <= 54; i++) begin
      pulse(1'b1, 1'b0, 1'b1);
      if (i == 52 || i == 53 || i == 54) check_tod($sformatf("set_min_%0d", i));
    end
    exit_set();

    // Full-day rollover 23:59:59 -> 00:00:00.
    do_reset();
    enter_set();
    for (int i = 0; i < 23; i++) pulse(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 59; i++) pulse(1'b1, 1'b0, 1'b1);
    check_tod("set_23_59");
    exit_set();
    run_ticks(58);
    check_tod("at_23_59_58");
    run_ticks(1);
    check_tod("at_23_59_59");
    run_ticks(1);
    check_tod("day_rollover");

    // Both buttons in one cycle at 23:59 -> 00:00 on the third edge.
    enter_set();
    for (int i = 0; i < 23; i++) pulse(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 59; i++) pulse(1'b1, 1'b0, 1'b1);
    check_tod("set_23_59_again");
    inc_min = 1'b1; inc_hour = 1'b1;
    step();
    inc_min = 1'b0; inc_hour = 1'b0;
    check_tod("dual_edge1");
    step();
    check_tod("dual_edge2");
    step();
    em = 0; eh = 0;
    check_tod("dual_edge3");

    // Leaving SET: first tick on the 4th edge after state returns to RUN.
    es = 1;
    exp_q.push_back(model_tod());
    set_mode = 1'b0; run = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      check($sformatf("exit_tick_c%0d", c), {31'd0, sec_tick}, {31'd0, (c == 7)});
    end
    run = 1'b0;
    step();
    check("exit_queue_empty", exp_q.size(), 32'd0);

    // Reset mid-SET with buttons held; held buttons do not count after release.
    do_reset();
    enter_set();
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b1);
    inc_min = 1'b1; inc_hour = 1'b1;
    repeat (3) step();
    em = em + 1; eh = eh + 1;
    check_tod("held_press");
    reset = 1'b1;
    step();
    eh = 0; em = 0; es = 0;
    check_tod("reset_mid_set");
    reset = 1'b0;
    repeat (8) step();
    check_tod("held_through_reset");
    inc_min = 1'b0; inc_hour = 1'b0;
    repeat (3) step();
    pulse(1'b1, 1'b0, 1'b1);
    check_tod("repress_after_reset");
    exit_set();

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
